// File: rtl/mem_arb_pkg.sv
// Shared types for the memory phase arbiter: phase encoding, RAM owner, read-return tag.
package mem_arb_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PROC = 2'd1,
        XMIT = 2'd2,
        DONE = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        OWN_U    = 2'd0,
        OWN_P    = 2'd1,
        OWN_NONE = 2'd2
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    function automatic owner_t phase_owner(input phase_t ph);
        case (ph)
            LOAD, XMIT: phase_owner = OWN_U;
            PROC:       phase_owner = OWN_P;
            default:    phase_owner = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the exit tag marks which side owns m_dout this cycle.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1  // legal 1..RD_LAT_MAX
) (
    input  logic    clock,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_pending
);

    rd_tag_t stage [RD_LAT];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < RD_LAT; i++) any_pending = any_pending | stage[i].valid;
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/mem_phase_arbiter.sv
// Single-port RAM arbiter driven by a LOAD -> PROC -> XMIT -> DONE phase FSM.
// Ownership changes only once the command register and the read-tag pipe are empty.
module mem_phase_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p_enable,
    input  logic              p_finish,
    input  logic              tx_done,
    input  logic              u_req,
    input  logic              u_wr,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_din,
    output logic              u_gnt,
    output logic [DATA_W-1:0] u_dout,
    output logic              u_dvalid,
    input  logic              p_req,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_din,
    output logic              p_gnt,
    output logic [DATA_W-1:0] p_dout,
    output logic              p_dvalid,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout,
    output logic              tx_start,
    output logic [1:0]        phase,
    output logic              err
);

    phase_t  state, next_state;
    owner_t  owner, cmd_owner;
    logic    sw, ill, in_flight, tx_lat, any_pending;
    rd_tag_t tag_in, tag_out;

    assign in_flight = m_en | any_pending;

    // State register; tx_done seen while draining is kept in tx_lat so the pulse is not lost.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= LOAD;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_lat   <= 1'b0;
        end else begin
            state    <= next_state;
            err      <= err | ill;
            tx_start <= (next_state == XMIT) && (state != XMIT);
            tx_lat   <= (state == XMIT) && (next_state == XMIT) && (tx_done || tx_lat);
        end
    end

    always_comb begin
        next_state = state;
        sw         = 1'b0;
        ill        = (p_finish & ~p_enable) | ((state == PROC) & ~p_enable) |
                     ((state != XMIT) & tx_done);
        case (state)
            LOAD:    sw = p_enable & ~p_finish;
            PROC:    sw = p_enable & p_finish;
            XMIT:    sw = tx_done | tx_lat;
            default: sw = ~p_enable & ~p_finish;
        endcase
        if (sw && !ill && !in_flight) begin
            case (state)
                LOAD:    next_state = PROC;
                PROC:    next_state = XMIT;
                XMIT:    next_state = DONE;
                default: next_state = LOAD;
            endcase
        end
    end

    always_comb begin
        owner    = phase_owner(state);
        phase    = state;
        u_gnt    = u_req & (owner == OWN_U) & ~sw;
        p_gnt    = p_req & (owner == OWN_P) & ~sw;
        u_dout   = m_dout;
        p_dout   = m_dout;
        u_dvalid = tag_out.valid & (tag_out.owner == OWN_U);
        p_dvalid = tag_out.valid & (tag_out.owner == OWN_P);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m_en      <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_din     <= '0;
            cmd_owner <= OWN_NONE;
        end else if (u_gnt) begin
            m_en      <= 1'b1;
            m_wr      <= u_wr;
            m_addr    <= u_addr;
            m_din     <= u_din;
            cmd_owner <= OWN_U;
        end else if (p_gnt) begin
            m_en      <= 1'b1;
            m_wr      <= p_wr;
            m_addr    <= p_addr;
            m_din     <= p_din;
            cmd_owner <= OWN_P;
        end else begin
            m_en      <= 1'b0;
            m_wr      <= 1'b0;
        end
    end

    // A read tag enters the pipe in the same cycle its command is on the RAM port.
    assign tag_in = '{valid: m_en & ~m_wr, owner: cmd_owner};

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
        .clock       (clock),
        .reset_n     (reset_n),
        .tag_in      (tag_in),
        .tag_out     (tag_out),
        .any_pending (any_pending)
    );

endmodule

// File: tb/tb_mem_phase_arbiter.sv
// Directed bench: RD_LAT=1 instance for phase flow and read returns, RD_LAT=3 instance for reset mid-burst.
module tb_mem_phase_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n, p_enable, p_finish, tx_done;
    logic          u_req, u_wr, u_gnt, u_dvalid, p_req, p_wr, p_gnt, p_dvalid;
    logic [AW-1:0] u_addr, p_addr, m_addr;
    logic [DW-1:0] u_din, p_din, u_dout, p_dout, m_din, m_dout;
    logic          m_en, m_wr, tx_start, err;
    logic [1:0]    phase;

    logic          b_rst_n, b_p_enable, b_p_req;
    logic [AW-1:0] b_p_addr, b_m_addr;
    logic          b_u_gnt, b_u_dvalid, b_p_gnt, b_p_dvalid, b_m_en, b_m_wr, b_tx_start, b_err;
    logic [DW-1:0] b_u_dout, b_p_dout, b_m_din;
    logic [1:0]    b_phase;

    mem_phase_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clock(clock), .reset_n(reset_n), .p_enable(p_enable), .p_finish(p_finish),
        .tx_done(tx_done), .u_req(u_req), .u_wr(u_wr), .u_addr(u_addr), .u_din(u_din),
        .u_gnt(u_gnt), .u_dout(u_dout), .u_dvalid(u_dvalid), .p_req(p_req), .p_wr(p_wr),
        .p_addr(p_addr), .p_din(p_din), .p_gnt(p_gnt), .p_dout(p_dout), .p_dvalid(p_dvalid),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
        .tx_start(tx_start), .phase(phase), .err(err)
    );

    mem_phase_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_lat3 (
        .clock(clock), .reset_n(b_rst_n), .p_enable(b_p_enable), .p_finish(1'b0),
        .tx_done(1'b0), .u_req(1'b0), .u_wr(1'b0), .u_addr('0), .u_din('0),
        .u_gnt(b_u_gnt), .u_dout(b_u_dout), .u_dvalid(b_u_dvalid), .p_req(b_p_req), .p_wr(1'b0),
        .p_addr(b_p_addr), .p_din('0), .p_gnt(b_p_gnt), .p_dout(b_p_dout), .p_dvalid(b_p_dvalid),
        .m_en(b_m_en), .m_wr(b_m_wr), .m_addr(b_m_addr), .m_din(b_m_din), .m_dout(8'h3C),
        .tx_start(b_tx_start), .phase(b_phase), .err(b_err)
    );

    // RAM model, one-cycle read latency
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_q;
    always @(posedge clock) begin
        if (m_en && m_wr)  mem[m_addr[7:0]] <= m_din;
        if (m_en && !m_wr) rd_q <= mem[m_addr[7:0]];
    end
    assign m_dout = rd_q;

    // scoreboard: entries are {side(0=u,1=p), data}
    logic [DW:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int b_dv_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic u_cmd(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        u_req = req; u_wr = wr; u_addr = a; u_din = d;
    endtask

    task automatic p_cmd(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req = req; p_wr = wr; p_addr = a; p_din = d;
    endtask

    initial begin
        reset_n = 1'b0; p_enable = 1'b0; p_finish = 1'b0; tx_done = 1'b0;
        u_cmd(1'b0, 1'b0, '0, '0);
        p_cmd(1'b0, 1'b0, '0, '0);
        b_rst_n = 1'b0; b_p_enable = 1'b0; b_p_req = 1'b0; b_p_addr = '0;

        // monitor: pops the expected queue whenever a read returns
        fork
            forever begin
                mid();
                if (b_u_dvalid || b_p_dvalid) b_dv_seen++;
                if (u_dvalid && p_dvalid) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dvalid_both: u_dvalid=1 p_dvalid=1, required at most one");
                end else if (u_dvalid || p_dvalid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_dvalid: u=%0b p=%0b, required no return", u_dvalid, p_dvalid);
                    end else begin
                        check("rd_return", {p_dvalid, p_dvalid ? p_dout : u_dout}, exp_q.pop_front());
                    end
                end
            end
        join_none

        // reset state
        step(); step(); mid();
        check("rst_phase", phase, 0);
        check("rst_err", err, 0);
        check("rst_m_en", m_en, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_dvalid", {u_dvalid, p_dvalid}, 0);

        // 1: u write then u read
        step(); reset_n = 1'b1; u_cmd(1'b1, 1'b1, 16'h0010, 8'hA5); mid();
        check("t1_u_gnt_wr", u_gnt, 1);
        check("t1_p_gnt", p_gnt, 0);
        step(); u_cmd(1'b1, 1'b0, 16'h0010, 8'h00); exp_q.push_back({1'b0, 8'hA5}); mid();
        check("t1_m_cmd_wr", {m_en, m_wr, m_addr, m_din}, {1'b1, 1'b1, 16'h0010, 8'hA5});
        check("t1_u_gnt_rd", u_gnt, 1);
        step(); u_req = 1'b0; mid();
        check("t1_m_cmd_rd", {m_en, m_wr}, 2'b10);
        step(); mid();
        check("t1_u_dvalid", {u_dvalid, u_dout}, {1'b1, 8'hA5});
        check("t1_p_dvalid", p_dvalid, 0);
        check("t1_m_idle", m_en, 0);

        // 2: drain before LOAD -> PROC
        step(); u_cmd(1'b1, 1'b0, 16'h0010, 8'h00); exp_q.push_back({1'b0, 8'hA5}); mid();
        check("t2_u_gnt_first", u_gnt, 1);
        step(); p_enable = 1'b1; mid();
        check("t2_u_gnt_blocked", u_gnt, 0);
        check("t2_phase_drain1", phase, 0);
        step(); mid();
        check("t2_phase_drain2", phase, 0);
        check("t2_u_dvalid", u_dvalid, 1);
        step(); u_req = 1'b0; mid();
        check("t2_phase_drain3", phase, 0);

        // 2/6: PROC, p side granted, u side held off
        step(); u_cmd(1'b1, 1'b0, 16'h0020, 8'h77); p_cmd(1'b1, 1'b0, 16'h0010, 8'h00);
        exp_q.push_back({1'b1, 8'hA5}); mid();
        check("t2_phase_proc", phase, 1);
        check("t2_p_gnt", p_gnt, 1);
        check("t6_u_gnt0", u_gnt, 0);
        step(); p_cmd(1'b1, 1'b1, 16'h0030, 8'h5C); mid();
        check("t6_m_cmd_prd", {m_en, m_wr, m_addr}, {1'b1, 1'b0, 16'h0010});
        check("t6_u_gnt1", u_gnt, 0);
        step(); p_req = 1'b0; mid();
        check("t6_m_cmd_pwr", {m_en, m_wr, m_addr, m_din}, {1'b1, 1'b1, 16'h0030, 8'h5C});
        step(); p_cmd(1'b1, 1'b0, 16'h0030, 8'h00); exp_q.push_back({1'b1, 8'h5C}); mid();
        check("t6_m_en_idle", m_en, 0);
        check("t6_u_gnt2", u_gnt, 0);

        // 3: PROC -> XMIT -> DONE -> LOAD
        step(); p_req = 1'b0; p_finish = 1'b1; mid();
        check("t3_m_en_rd", m_en, 1);
        check("t3_phase_drain1", phase, 1);
        step(); u_req = 1'b0; mid();
        check("t3_phase_drain2", phase, 1);
        step(); mid();
        check("t3_phase_drain3", phase, 1);
        check("t3_tx_start_pre", tx_start, 0);
        step(); mid();
        check("t3_phase_xmit", phase, 2);
        check("t3_tx_start", tx_start, 1);
        step(); tx_done = 1'b1; mid();
        check("t3_tx_start_once", tx_start, 0);
        check("t3_phase_xmit2", phase, 2);
        step(); tx_done = 1'b0; p_enable = 1'b0; p_finish = 1'b0; mid();
        check("t3_phase_done", phase, 3);
        step(); mid();
        check("t3_phase_load", phase, 0);
        check("t3_err_clean", err, 0);

        // 4: p_finish without p_enable in LOAD
        step(); p_finish = 1'b1; mid();
        step(); p_finish = 1'b0; mid();
        check("t4_err_set", err, 1);
        check("t4_phase_held", phase, 0);
        step(); mid();
        check("t4_err_sticky", err, 1);
        step(); reset_n = 1'b0; mid();
        step(); reset_n = 1'b1; mid();
        check("t4_err_cleared", err, 0);

        // tx_done outside XMIT
        step(); tx_done = 1'b1; mid();
        step(); tx_done = 1'b0; mid();
        check("txd_err_set", err, 1);
        check("txd_phase", phase, 0);

        // 5: RD_LAT=3, reset in the middle of a p read burst
        step(); b_rst_n = 1'b1; b_p_enable = 1'b1; mid();
        check("t5_phase_load", b_phase, 0);
        step(); b_p_req = 1'b1; b_p_addr = 16'h0001; mid();
        check("t5_phase_proc", b_phase, 1);
        check("t5_p_gnt", b_p_gnt, 1);
        step(); b_p_addr = 16'h0002; mid();
        check("t5_m_cmd1", {b_m_en, b_m_addr}, {1'b1, 16'h0001});
        step(); b_p_addr = 16'h0003; b_rst_n = 1'b0; mid();
        check("t5_m_cmd2", {b_m_en, b_m_addr}, {1'b1, 16'h0002});
        step(); b_rst_n = 1'b1; b_p_req = 1'b0; b_p_enable = 1'b0; mid();
        check("t5_phase_after_rst", b_phase, 0);
        check("t5_m_after_rst", {b_m_en, b_m_addr}, {1'b0, 16'h0000});
        for (int i = 0; i < 8; i++) step();
        mid();
        check("t5_no_dvalid", b_dv_seen, 0);
        check("t5_err", b_err, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
